// File: rtl/baverage_alarm_pkg.sv
// Shared types and sizing helpers for the baverage alarm debouncer.
package baverage_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    ALARM     = 2'd2,
    RELEASING = 2'd3
  } alarm_state_t;

  // Run counter must hold values up to the larger of the two thresholds.
  function automatic int run_width(input int hold, input int release_n);
    int m;
    m = (hold > release_n) ? hold : release_n;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/baverage_alarm_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/baverage_alarm.sv
// Debounces the baverage threshold flag into a hysteretic alarm with a
// sticky acknowledged copy and a saturating episode counter.
module baverage_alarm
  import baverage_alarm_pkg::*;
#(
  parameter int HOLD    = 3,
  parameter int RELEASE = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             ack,
  output logic             alarm,
  output logic             alarm_latched,
  output logic [CNT_W-1:0] event_count
);

  localparam int RUN_W = run_width(HOLD, RELEASE);

  alarm_state_t     state;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic             hold_done;
  logic             release_done;
  logic             rise;

  assign run_inc      = run + RUN_W'(1);
  assign hold_done    = (run_inc == RUN_W'(HOLD));
  assign release_done = (run_inc == RUN_W'(RELEASE));

  // A rise is any entry into ALARM from IDLE or ARMING; RELEASING->ALARM is not.
  always_comb begin
    rise = 1'b0;
    case (state)
      IDLE:    rise = y && (HOLD == 1);
      ARMING:  rise = y && hold_done;
      default: rise = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      run           <= '0;
      alarm         <= 1'b0;
      alarm_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (y) begin
            if (HOLD == 1) begin
              state <= ALARM;
              run   <= '0;
              alarm <= 1'b1;
            end else begin
              state <= ARMING;
              run   <= RUN_W'(1);
            end
          end
        end
        ARMING: begin
          if (!y) begin
            state <= IDLE;
            run   <= '0;
          end else if (hold_done) begin
            state <= ALARM;
            run   <= '0;
            alarm <= 1'b1;
          end else begin
            run <= run_inc;
          end
        end
        ALARM: begin
          if (!y) begin
            if (RELEASE == 1) begin
              state <= IDLE;
              run   <= '0;
              alarm <= 1'b0;
            end else begin
              state <= RELEASING;
              run   <= RUN_W'(1);
            end
          end
        end
        RELEASING: begin
          if (y) begin
            state <= ALARM;
            run   <= '0;
          end else if (release_done) begin
            state <= IDLE;
            run   <= '0;
            alarm <= 1'b0;
          end else begin
            run <= run_inc;
          end
        end
        default: begin
          state <= IDLE;
          run   <= '0;
          alarm <= 1'b0;
        end
      endcase

      // A set on a rise edge beats a simultaneous acknowledge.
      if (rise) begin
        alarm_latched <= 1'b1;
      end else if (ack && !alarm) begin
        alarm_latched <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_event_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rise),
    .q   (event_count)
  );

endmodule
